// File: rtl/ps2_pkg.sv
// Shared definitions for the device-side PS/2 transmitter: FSM states,
// frame bit positions, default timing and the frame bit lookup.
package ps2_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      HOLDOFF = 3'd1,
      BIT_HI  = 3'd2,
      BIT_LO  = 3'd3,
      INHIBIT = 3'd4,
      GAP     = 3'd5
   } state_t;

   // Positions within the 11-bit frame
   localparam logic [3:0] START_IDX = 4'd0;
   localparam logic [3:0] PAR_IDX   = 4'd9;
   localparam logic [3:0] STOP_IDX  = 4'd10;

   // Default timing in system clock cycles (50 MHz -> 12.5 kHz PS2_CLK)
   localparam int HALF_CLKS_DEF = 2000;
   localparam int HOLD_CLKS_DEF = 2500;
   localparam int GAP_CLKS_DEF  = 4000;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   // Line level of frame bit idx: start 0, data LSB first, parity, stop 1
   function automatic logic frame_bit(input logic [7:0] data,
                                      input logic       par,
                                      input logic [3:0] idx);
      logic b;
      case (idx)
         START_IDX: b = 1'b0;
         PAR_IDX:   b = par;
         STOP_IDX:  b = 1'b1;
         default:   b = data[idx[2:0] - 3'd1];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/ps2_sync2.sv
// Two-flop synchroniser for an asynchronous PS/2 pin level.
// Resets to the idle (released, high) line level.
module ps2_sync2 #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_q;

   // Double-register the pin to settle metastability
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_meta <= RST_VAL;
         r_q    <= RST_VAL;
      end else begin
         r_meta <= i_d;
         r_q    <= r_meta;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/ps2_device_tx.sv
// Device-side (keyboard end) PS/2 transmitter. Serialises bytes into
// 11-bit frames, generates PS2_CLK itself and drives both lines
// open-drain through *_oe (1 = pull low). A host pulling the clock low
// during a bit aborts the frame, which is then retransmitted in full.
// Optional build macro PS2_TX_ERRINJ_EN adds err_inj, which inverts the
// parity bit of the accepted byte (kept across retransmissions).
module ps2_device_tx
   import ps2_pkg::*;
#(
   parameter int HALF_CLKS = HALF_CLKS_DEF,
   parameter int HOLD_CLKS = HOLD_CLKS_DEF,
   parameter int GAP_CLKS  = GAP_CLKS_DEF
) (
   input  logic       CLOCK_50,
   input  logic       resetn,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
`ifdef PS2_TX_ERRINJ_EN
   input  logic       err_inj,
`endif
   output logic       tx_ready,
   input  logic       ps2_clk_in,
   input  logic       ps2_dat_in,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe,
   output logic       busy,
   output logic       tx_done,
   output logic       tx_aborted
);

   localparam int MAX_CLKS = max3(HALF_CLKS, HOLD_CLKS, GAP_CLKS);
   localparam int CW       = $clog2(MAX_CLKS) + 1;

   localparam logic [CW-1:0] HALF_LD = CW'(HALF_CLKS);
   localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CLKS);
   localparam logic [CW-1:0] GAP_LD  = CW'(GAP_CLKS);
   // Inhibit is only trusted from the 3rd cycle of a high phase: the
   // released clock needs two synchroniser cycles to read back high.
   localparam logic [CW-1:0] INH_LD  = CW'(HALF_CLKS - 2);
   localparam logic [CW-1:0] ONE     = CW'(1);

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic [3:0]    r_idx;
   logic [7:0]    r_data;
   logic          r_par;
   logic          r_clk_oe;
   logic          r_dat_oe;
   logic          r_done;
   logic          r_abort;

   logic          w_clk_s;
   logic          w_dat_s;
   logic          w_par;
   logic          w_last;
   logic          w_inh_win;
   logic [3:0]    w_idx_nxt;

   ps2_sync2 #(.RST_VAL(1'b1)) u_sync_clk (
      .i_clk   (CLOCK_50),
      .i_rst_n (resetn),
      .i_d     (ps2_clk_in),
      .o_q     (w_clk_s)
   );

   ps2_sync2 #(.RST_VAL(1'b1)) u_sync_dat (
      .i_clk   (CLOCK_50),
      .i_rst_n (resetn),
      .i_d     (ps2_dat_in),
      .o_q     (w_dat_s)
   );

`ifdef PS2_TX_ERRINJ_EN
   assign w_par = ~^tx_data ^ err_inj;
`else
   assign w_par = ~^tx_data;
`endif

   assign w_last    = (r_cnt == ONE);
   assign w_inh_win = (r_cnt <= INH_LD);
   assign w_idx_nxt = r_idx + 4'd1;

   // Frame FSM: one shared down-counter reloaded on every state entry
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_idx    <= START_IDX;
         r_data   <= '0;
         r_par    <= 1'b0;
         r_clk_oe <= 1'b0;
         r_dat_oe <= 1'b0;
         r_done   <= 1'b0;
         r_abort  <= 1'b0;
      end else begin
         r_done  <= 1'b0;
         r_abort <= 1'b0;
         case (r_state)
            IDLE: begin
               r_clk_oe <= 1'b0;
               r_dat_oe <= 1'b0;
               if (tx_valid) begin
                  r_data  <= tx_data;
                  r_par   <= w_par;
                  r_cnt   <= HOLD_LD;
                  r_state <= HOLDOFF;
               end
            end

            HOLDOFF: begin
               if (w_clk_s && w_dat_s) begin
                  if (w_last) begin
                     r_idx    <= START_IDX;
                     r_cnt    <= HALF_LD;
                     r_clk_oe <= 1'b0;
                     r_dat_oe <= ~frame_bit(r_data, r_par, START_IDX);
                     r_state  <= BIT_HI;
                  end else begin
                     r_cnt <= r_cnt - ONE;
                  end
               end else begin
                  r_cnt <= HOLD_LD;
               end
            end

            BIT_HI: begin
               if (!w_clk_s && w_inh_win && (r_idx <= PAR_IDX)) begin
                  r_clk_oe <= 1'b0;
                  r_dat_oe <= 1'b0;
                  r_abort  <= 1'b1;
                  r_cnt    <= HOLD_LD;
                  r_state  <= INHIBIT;
               end else if (w_last) begin
                  r_clk_oe <= 1'b1;
                  r_cnt    <= HALF_LD;
                  r_state  <= BIT_LO;
               end else begin
                  r_cnt <= r_cnt - ONE;
               end
            end

            BIT_LO: begin
               if (w_last) begin
                  r_clk_oe <= 1'b0;
                  if (r_idx == STOP_IDX) begin
                     r_dat_oe <= 1'b0;
                     r_done   <= 1'b1;
                     r_cnt    <= GAP_LD;
                     r_state  <= GAP;
                  end else begin
                     r_idx    <= w_idx_nxt;
                     r_dat_oe <= ~frame_bit(r_data, r_par, w_idx_nxt);
                     r_cnt    <= HALF_LD;
                     r_state  <= BIT_HI;
                  end
               end else begin
                  r_cnt <= r_cnt - ONE;
               end
            end

            INHIBIT: begin
               r_clk_oe <= 1'b0;
               r_dat_oe <= 1'b0;
               if (w_clk_s) begin
                  if (w_last) begin
                     r_idx   <= START_IDX;
                     r_cnt   <= HOLD_LD;
                     r_state <= HOLDOFF;
                  end else begin
                     r_cnt <= r_cnt - ONE;
                  end
               end else begin
                  r_cnt <= HOLD_LD;
               end
            end

            GAP: begin
               r_clk_oe <= 1'b0;
               r_dat_oe <= 1'b0;
               if (w_last) begin
                  r_state <= IDLE;
               end else begin
                  r_cnt <= r_cnt - ONE;
               end
            end

            default: begin
               r_clk_oe <= 1'b0;
               r_dat_oe <= 1'b0;
               r_state  <= IDLE;
            end
         endcase
      end
   end

   assign tx_ready   = (r_state == IDLE);
   assign busy       = (r_state != IDLE);
   assign ps2_clk_oe = r_clk_oe;
   assign ps2_dat_oe = r_dat_oe;
   assign tx_done    = r_done;
   assign tx_aborted = r_abort;

endmodule

// File: tb/tb_ps2_device_tx.sv
// Directed bench for ps2_device_tx with a host-side frame monitor on the
// open-drain lines. Define PS2_TX_ERRINJ_EN to also cover parity injection.
module tb_ps2_device_tx;

   localparam int HALF  = 4;
   localparam int HOLD  = 6;
   localparam int GAPC  = 8;
   localparam int LIMIT = 2000;

   logic       CLOCK_50 = 1'b0;
   logic       resetn   = 1'b0;
   logic [7:0] tx_data  = 8'h00;
   logic       tx_valid = 1'b0;
`ifdef PS2_TX_ERRINJ_EN
   logic       err_inj  = 1'b0;
`endif
   logic       tx_ready, ps2_clk_oe, ps2_dat_oe, busy, tx_done, tx_aborted;
   logic       host_inh = 1'b0;
   wire        clk_line = ~ps2_clk_oe & ~host_inh;
   wire        dat_line = ~ps2_dat_oe;

   int n_tests = 0;
   int n_fail  = 0;

   ps2_device_tx #(.HALF_CLKS(HALF), .HOLD_CLKS(HOLD), .GAP_CLKS(GAPC)) dut (
      .CLOCK_50   (CLOCK_50),
      .resetn     (resetn),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
`ifdef PS2_TX_ERRINJ_EN
      .err_inj    (err_inj),
`endif
      .tx_ready   (tx_ready),
      .ps2_clk_in (clk_line),
      .ps2_dat_in (dat_line),
      .ps2_clk_oe (ps2_clk_oe),
      .ps2_dat_oe (ps2_dat_oe),
      .busy       (busy),
      .tx_done    (tx_done),
      .tx_aborted (tx_aborted)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   // Host monitor: samples the data line on each device-driven clock fall
   logic [10:0] mon_bits;
   logic [3:0]  mon_cnt;
   logic        mon_prev;
   logic [10:0] rx_q[$];
   int          done_cnt = 0;
   int          ab_cnt   = 0;

   always @(negedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         mon_cnt  <= 4'd0;
         mon_prev <= 1'b0;
         mon_bits <= '0;
      end else begin
         mon_prev <= ps2_clk_oe;
         if (tx_aborted) begin
            mon_cnt <= 4'd0;
         end else if (ps2_clk_oe && !mon_prev) begin
            mon_bits[mon_cnt] <= dat_line;
            if (mon_cnt == 4'd10) begin
               rx_q.push_back({dat_line, mon_bits[9:0]});
               mon_cnt <= 4'd0;
            end else begin
               mon_cnt <= mon_cnt + 4'd1;
            end
         end
      end
   end

   always @(negedge CLOCK_50) begin
      if (tx_done)    done_cnt <= done_cnt + 1;
      if (tx_aborted) ab_cnt   <= ab_cnt + 1;
   end

   task automatic tick();
      @(negedge CLOCK_50);
   endtask

   task automatic send(input logic [7:0] b);
      int n;
      n = 0;
      tx_data  = b;
      tx_valid = 1'b1;
      while (!tx_ready && n < LIMIT) begin tick(); n++; end
      n_tests++;
      if (n >= LIMIT) begin n_fail++; $display("FAIL send_timeout got ready=%b want 1", tx_ready); end
      tick();
      tx_valid = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while (!tx_done && n < LIMIT) begin tick(); n++; end
      n_tests++;
      if (n >= LIMIT) begin n_fail++; $display("FAIL %s done_timeout got tx_done=0 want 1", name); end
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (!tx_ready && n < LIMIT) begin tick(); n++; end
      n_tests++;
      if (n >= LIMIT) begin n_fail++; $display("FAIL %s idle_timeout got tx_ready=0 want 1", name); end
   endtask

   task automatic wait_rises(input int cnt, input string name);
      int n, r;
      logic p;
      n = 0; r = 0; p = ps2_clk_oe;
      while (r < cnt && n < LIMIT) begin
         tick(); n++;
         if (ps2_clk_oe && !p) r++;
         p = ps2_clk_oe;
      end
      n_tests++;
      if (r < cnt) begin n_fail++; $display("FAIL %s rise_timeout got %0d want %0d", name, r, cnt); end
   endtask

   task automatic check_frame(input string name, input int idx, input logic [10:0] want);
      n_tests++;
      if (rx_q.size() <= idx) begin
         n_fail++; $display("FAIL %s frame_missing got %0d frames want >%0d", name, rx_q.size(), idx);
      end else if (rx_q[idx] !== want) begin
         n_fail++; $display("FAIL %s frame got %b want %b", name, rx_q[idx], want);
      end
   endtask

   task automatic test_reset();
      n_tests++;
      if ({ps2_clk_oe, ps2_dat_oe} !== 2'b00) begin
         n_fail++; $display("FAIL reset_oe got %b want 00", {ps2_clk_oe, ps2_dat_oe});
      end
      n_tests++;
      if ({tx_ready, busy} !== 2'b10) begin
         n_fail++; $display("FAIL reset_ready_busy got %b want 10", {tx_ready, busy});
      end
      n_tests++;
      if ({tx_done, tx_aborted} !== 2'b00) begin
         n_fail++; $display("FAIL reset_pulses got %b want 00", {tx_done, tx_aborted});
      end
   endtask

   task automatic test_basic();
      int base, d0, k;
      base = rx_q.size(); d0 = done_cnt;
      send(8'h1C);
      n_tests++;
      if (busy !== 1'b1 || tx_ready !== 1'b0) begin
         n_fail++; $display("FAIL basic_busy got busy=%b ready=%b want 1 0", busy, tx_ready);
      end
      k = 0;
      while (!ps2_dat_oe && k < LIMIT) begin tick(); k++; end
      k = 0;
      while (!tx_done && k < LIMIT) begin tick(); k++; end
      n_tests++;
      if (k != 22 * HALF) begin n_fail++; $display("FAIL basic_duration got %0d want %0d", k, 22 * HALF); end
      tick();
      n_tests++;
      if (tx_done !== 1'b0) begin n_fail++; $display("FAIL basic_done_width got %b want 0", tx_done); end
      wait_idle("basic");
      check_frame("basic_1C", base, 11'b1_0_00011100_0);
      n_tests++;
      if (rx_q.size() != base + 1 || done_cnt - d0 != 1) begin
         n_fail++; $display("FAIL basic_counts got frames=%0d dones=%0d want 1 1", rx_q.size() - base, done_cnt - d0);
      end
   endtask

   task automatic test_back_to_back();
      int base, k;
      base = rx_q.size();
      send(8'hF0);
      tx_data  = 8'h1C;
      tx_valid = 1'b1;
      n_tests++;
      if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_busy got %b want 0", tx_ready); end
      wait_done("b2b_first");
      k = 0;
      while (!tx_ready && k < LIMIT) begin tick(); k++; end
      n_tests++;
      if (k != GAPC) begin n_fail++; $display("FAIL b2b_gap got %0d want %0d", k, GAPC); end
      tick();
      tx_valid = 1'b0;
      wait_done("b2b_second");
      wait_idle("b2b");
      check_frame("b2b_F0", base, 11'b1_1_11110000_0);
      check_frame("b2b_1C", base + 1, 11'b1_0_00011100_0);
   endtask

   task automatic test_inhibit();
      int base, a0, d0, n;
      base = rx_q.size(); a0 = ab_cnt; d0 = done_cnt;
      send(8'h5A);
      wait_rises(3, "inh");
      n = 0;
      while (ps2_clk_oe && n < LIMIT) begin tick(); n++; end
      host_inh = 1'b1;
      repeat (20) tick();
      n_tests++;
      if (ab_cnt - a0 != 1) begin n_fail++; $display("FAIL inh_abort_pulse got %0d want 1", ab_cnt - a0); end
      n_tests++;
      if ({ps2_clk_oe, ps2_dat_oe, busy} !== 3'b001) begin
         n_fail++; $display("FAIL inh_release got %b want 001", {ps2_clk_oe, ps2_dat_oe, busy});
      end
      host_inh = 1'b0;
      wait_done("inh");
      wait_idle("inh");
      check_frame("inh_5A", base, 11'b1_1_01011010_0);
      n_tests++;
      if (rx_q.size() != base + 1 || done_cnt - d0 != 1) begin
         n_fail++; $display("FAIL inh_once got frames=%0d dones=%0d want 1 1", rx_q.size() - base, done_cnt - d0);
      end
   endtask

   task automatic test_stop_inhibit();
      int base, a0, n;
      base = rx_q.size(); a0 = ab_cnt;
      send(8'h77);
      wait_rises(10, "stopinh");
      n = 0;
      while (ps2_clk_oe && n < LIMIT) begin tick(); n++; end
      host_inh = 1'b1;
      repeat (3) tick();
      host_inh = 1'b0;
      wait_done("stopinh");
      wait_idle("stopinh");
      n_tests++;
      if (ab_cnt != a0) begin n_fail++; $display("FAIL stopinh_abort got %0d want 0", ab_cnt - a0); end
      check_frame("stopinh_77", base, 11'b1_1_01110111_0);
      n_tests++;
      if (rx_q.size() != base + 1) begin n_fail++; $display("FAIL stopinh_once got %0d want 1", rx_q.size() - base); end
   endtask

   task automatic test_reset_midframe();
      int base;
      send(8'h00);
      wait_rises(6, "rstmid");
      n_tests++;
      if (ps2_dat_oe !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_dat got %b want 1", ps2_dat_oe); end
      resetn = 1'b0;
      #1;
      n_tests++;
      if ({ps2_clk_oe, ps2_dat_oe} !== 2'b00) begin
         n_fail++; $display("FAIL rstmid_release got %b want 00", {ps2_clk_oe, ps2_dat_oe});
      end
      n_tests++;
      if ({tx_ready, busy} !== 2'b10) begin
         n_fail++; $display("FAIL rstmid_ready got %b want 10", {tx_ready, busy});
      end
      repeat (3) tick();
      resetn = 1'b1;
      repeat (2) tick();
      base = rx_q.size();
      send(8'h29);
      wait_done("rstmid");
      wait_idle("rstmid");
      check_frame("rstmid_29", base, 11'b1_0_00101001_0);
   endtask

`ifdef PS2_TX_ERRINJ_EN
   task automatic test_errinj();
      int base;
      base = rx_q.size();
      err_inj = 1'b1;
      send(8'h1C);
      err_inj = 1'b0;
      wait_done("errinj");
      wait_idle("errinj");
      check_frame("errinj_1C", base, 11'b1_1_00011100_0);
      n_tests++;
      if (rx_q.size() > base && (^rx_q[base][9:1]) !== 1'b0) begin
         n_fail++; $display("FAIL errinj_parity_ok got %b want 0", ^rx_q[base][9:1]);
      end
   endtask
`endif

   initial begin
      repeat (3) tick();
      test_reset();
      resetn = 1'b1;
      repeat (2) tick();
      test_basic();
      test_back_to_back();
      test_inhibit();
      test_stop_inhibit();
      test_reset_midframe();
`ifdef PS2_TX_ERRINJ_EN
      test_errinj();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/ps2_device_tx.md
Name: ps2_device_tx

Overview:
- Device-side PS/2 transmitter: the keyboard end of the link that PS2_Controller receives from.
- Serialises bytes (scan codes) into 11-bit PS/2 frames, generating PS2_CLK itself and driving both lines open-drain.
- Used as the keyboard stand-in for simulation benches and as an on-board loopback source feeding PS2_Controller.
- Honours host inhibit: clock held low by the host aborts the frame, which is then retransmitted.

Parameters:
HALF_CLKS, 2000, CLOCK_50 cycles per PS2_CLK half-period (12.5 kHz); must be >= 4
HOLD_CLKS, 2500, cycles both lines must read high before a start bit is issued
GAP_CLKS, 4000, idle cycles enforced after a stop bit before the next byte is accepted

Ports:
CLOCK_50  in  1  system clock
resetn  in  1  asynchronous active-low reset
tx_data  in  8  byte to send
tx_valid  in  1  tx_data valid
tx_ready  out  1  high when a byte can be accepted
ps2_clk_in  in  1  sensed PS2_CLK pin level, asynchronous
ps2_dat_in  in  1  sensed PS2_DAT pin level, asynchronous
ps2_clk_oe  out  1  1 = pull PS2_CLK low; 0 = release
ps2_dat_oe  out  1  1 = pull PS2_DAT low; 0 = release
busy  out  1  frame in progress, including holdoff, inhibit and gap
tx_done  out  1  one-cycle pulse when the stop bit completes
tx_aborted  out  1  one-cycle pulse when a frame is aborted by host inhibit

Behaviour:
- Reset values: ps2_clk_oe=0, ps2_dat_oe=0, tx_ready=1, busy=0, tx_done=0, tx_aborted=0. State goes to IDLE.
- Reset mid-frame: both lines are released immediately (asynchronous) and the latched byte is discarded.
- Pin inputs pass through two-flop synchronisers. All line checks use the synchronised values.
- Handshake: tx_ready = (state==IDLE).
  - A transfer happens on a cycle with tx_valid & tx_ready.
  - tx_data is latched into shift reg, and parity = ~^tx_data (odd parity) is computed.
  - tx_ready falls on the next cycle. Bytes are never dropped.
- Frame bits, index 0..10: start 0, data b0..b7 LSB first, parity, stop 1. Data line: oe = ~bit.
- State IDLE: lines released. On accept -> HOLDOFF.
- State HOLDOFF: counts HOLD_CLKS consecutive cycles with clk_in=1 and dat_in=1; any low level restarts the count. When the count completes -> BIT_HI, idx=0.
- State BIT_HI:
  - On entry, dat_oe is set for bit idx.
  - clk_oe=0 for HALF_CLKS cycles.
  - If synchronised clk_in=0 is seen at or after cycle 3 of this phase while idx<=9 -> INHIBIT.
  - When the count expires -> BIT_LO.
- State BIT_LO:
  - clk_oe=1 for HALF_CLKS cycles; the host samples on this falling edge.
  - At the end: if idx==10 -> GAP; else idx+1 -> BIT_HI.
- State INHIBIT:
  - Both oe released; tx_aborted pulses on entry.
  - Waits until clk_in has been high for HOLD_CLKS cycles, then -> HOLDOFF with the same byte and idx reset to 0 (full retransmit).
- Inhibit at idx==10 (stop bit) is ignored and the frame completes.
- State GAP: lines released; tx_done pulses on entry; waits GAP_CLKS cycles -> IDLE.
- busy = (state != IDLE).
- Frame duration from first start edge to end of stop bit = 22*HALF_CLKS cycles.
- Counters are sized $clog2 of the maximum of HALF_CLKS, HOLD_CLKS and GAP_CLKS, plus 1. A single shared down-counter is reloaded on each state entry.

Optional Feature:
- Macro: PS2_TX_ERRINJ_EN.
- When defined:
  - Adds input err_inj (1 bit), sampled at byte accept.
  - If err_inj is set, the parity bit of that frame is inverted.
  - If the frame is retransmitted, the retransmission keeps the inverted parity.
- When not defined: the port is absent and parity is always correct. Intended for exercising PS2_Controller's error path.

Decomposition:
- Shared package ps2_pkg holds:
  - the state enum (IDLE, HOLDOFF, BIT_HI, BIT_LO, INHIBIT, GAP);
  - the frame bit index constants START_IDX=0, PAR_IDX=9, STOP_IDX=10;
  - the default timing constants.
- One sub-module: ps2_sync2, a two-flop synchroniser instantiated once per pin input.

Test Plan:
- Loopback to PS2_Controller, HALF_CLKS=4, HOLD_CLKS=6, GAP_CLKS=8; send 0x1C -> dat_oe pattern (bit=0 means oe=1) follows 0,0,0,1,1,1,0,0,0,0,1 (parity 0); received_data=0x1C with one received_data_en; tx_done one pulse.
- Send 0xF0, then hold tx_valid with 0x1C -> parity bit 1 for 0xF0; second byte accepted only after GAP; host receives 0xF0 then 0x1C.
- Bench pulls clk_in low during BIT_HI at idx=3 while sending 0x5A -> tx_aborted pulse; lines released; full 11-bit retransmit after release+HOLD; host receives 0x5A exactly once.
- Inhibit during the stop bit (idx=10) -> no abort; tx_done pulses; byte delivered once.
- resetn asserted during BIT_LO at idx=5 -> ps2_clk_oe/ps2_dat_oe=0 in the same cycle; tx_ready=1 after release; the next byte is sent normally.
- PS2_TX_ERRINJ_EN defined, err_inj=1 with byte 0x1C -> parity bit 1 on the wire; PS2_Controller flags no received_data_en for that frame.
